// File: rtl/matrix_mac_sequencer.sv
// matrix_mac_sequencer: computes C = A x B for NxN row-major matrices held
// in a single-port word memory, one access per cycle (read A, read B, ..., write C).
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  request a run (sampled only in IDLE)
//   a_base/b_base/c_base   word base addresses of A, B, C (latched at start)
//   busy, done             run in progress / one-cycle end-of-run pulse
//   mem_address            word address to data memory
//   mem_write_data         store data
//   mem_write_enable       write commits at the next rising edge
//   mem_read_enable        read request
//   mem_read_data          combinational read data, same cycle as the request
module matrix_mac_sequencer #(
    parameter int N      = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a_base,
    input  logic [DATA_W-1:0] b_base,
    input  logic [DATA_W-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [DATA_W-1:0] NW = DATA_W'(N);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_C = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]     i, j, k;
    logic [DATA_W-1:0] acc, a_reg;
    logic [DATA_W-1:0] ab, bb, cb;

    logic [DATA_W-1:0] i_w, j_w, k_w;
    logic [DATA_W-1:0] row_off;
    logic [DATA_W-1:0] prod;
    logic              last_i, last_j, last_k;

    assign i_w     = DATA_W'(i);
    assign j_w     = DATA_W'(j);
    assign k_w     = DATA_W'(k);
    assign row_off = i_w * NW;
    // Truncated to DATA_W bits: arithmetic is modulo 2^DATA_W.
    assign prod    = a_reg * mem_read_data;
    assign last_i  = (i == LAST);
    assign last_j  = (j == LAST);
    assign last_k  = (k == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs depend only on registered state, counters and latched bases.
    always_comb begin
        state_n          = state;
        busy             = 1'b0;
        done             = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RD_A;
            end
            RD_A: begin
                busy            = 1'b1;
                mem_read_enable = 1'b1;
                mem_address     = ab + row_off + k_w;
                state_n         = RD_B;
            end
            RD_B: begin
                busy            = 1'b1;
                mem_read_enable = 1'b1;
                mem_address     = bb + k_w * NW + j_w;
                state_n         = last_k ? WR_C : RD_A;
            end
            WR_C: begin
                busy             = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = cb + row_off + j_w;
                mem_write_data   = acc;
                state_n          = (last_i && last_j) ? DONE : RD_A;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            a_reg <= '0;
            ab    <= '0;
            bb    <= '0;
            cb    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ab  <= a_base;
                        bb  <= b_base;
                        cb  <= c_base;
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                RD_A: a_reg <= mem_read_data;
                RD_B: begin
                    acc <= acc + prod;
                    if (!last_k) k <= k + 1'b1;
                end
                WR_C: begin
                    k   <= '0;
                    acc <= '0;
                    if (last_j) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Testbench for matrix_mac_sequencer: table-driven directed runs, random runs
// against a matrix-multiply reference, plus reset/start/back-to-back/N=1 cases.
module tb_matrix_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic        busy, done, we, re;
    logic [31:0] addr, wd, rd;

    logic        start1 = 1'b0;
    logic        busy1, done1, we1, re1;
    logic [31:0] addr1, wd1, rd1;

    logic        ld_en = 1'b0;
    logic [5:0]  ld_a = '0;
    logic [31:0] ld_d = '0;

    logic [31:0] mem  [64];
    logic [31:0] mem1 [4];
    logic [31:0] img  [64];

    int cmps = 0;
    int fails = 0;
    int wr_seen = 0;

    always #5 clk = ~clk;

    matrix_mac_sequencer #(.N(3), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done),
        .mem_address(addr), .mem_write_data(wd),
        .mem_write_enable(we), .mem_read_enable(re),
        .mem_read_data(rd)
    );

    matrix_mac_sequencer #(.N(1), .DATA_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_base(32'd0), .b_base(32'd1), .c_base(32'd2),
        .busy(busy1), .done(done1),
        .mem_address(addr1), .mem_write_data(wd1),
        .mem_write_enable(we1), .mem_read_enable(re1),
        .mem_read_data(rd1)
    );

    assign rd  = mem[addr[5:0]];
    assign rd1 = mem1[addr1[1:0]];

    always @(posedge clk) begin
        if (we) mem[addr[5:0]] <= wd;
        else if (ld_en) mem[ld_a] <= ld_d;
        if (we1) mem1[addr1[1:0]] <= wd1;
        else if (ld_en && ld_a < 6'd4) mem1[ld_a[1:0]] <= ld_d;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle; bus-level invariants checked on both instances.
    task automatic step();
        @(negedge clk);
        check("rw_excl", 32'(re && we), 32'd0);
        check("busy_dec", 32'(busy), 32'(re | we));
        if (!re && !we) begin
            check("idle_addr", addr, 32'd0);
            check("idle_wd", wd, 32'd0);
        end
        if (!re1 && !we1) check("idle_addr1", addr1, 32'd0);
        check("rw_excl1", 32'(re1 && we1), 32'd0);
        if (we) wr_seen++;
    endtask

    task automatic load();
        for (int w = 0; w < 64; w++) begin
            step();
            ld_en = 1'b1;
            ld_a  = 6'(w);
            ld_d  = img[w];
        end
        step();
        ld_en = 1'b0;
    endtask

    // One run; runs a fixed 80-cycle window, returns first done cycle,
    // number of done pulses and writes seen.
    task automatic run3(input bit extra, output int dn_at,
                        output int ndone, output int nwr);
        int w0;
        step();
        start = 1'b1;
        w0 = wr_seen;
        dn_at = -1;
        ndone = 0;
        for (int n = 1; n <= 80; n++) begin
            step();
            if (done) begin
                ndone++;
                if (dn_at < 0) dn_at = n;
            end
            start = extra && (n == 5 || n == 40);
        end
        nwr = wr_seen - w0;
    endtask

    // Reference: C = A x B, modulo 2^32, from the loaded image.
    function automatic logic [31:0] ref_c(int ab, int bb, int i, int j);
        logic [31:0] s = 0;
        for (int k = 0; k < 3; k++) s += img[ab + i*3 + k] * img[bb + k*3 + j];
        return s;
    endfunction

    typedef struct packed {
        logic [1:0]   mode;
        logic [287:0] exp;
    } vec_t;

    vec_t tab [3];

    task automatic fill(input logic [1:0] mode);
        for (int w = 0; w < 64; w++) img[w] = 32'hDEAD0000 + 32'(w);
        for (int w = 0; w < 18; w++) begin
            unique case (mode)
                2'd0: img[w] = 32'(w % 3 + 1);
                2'd1: img[w] = 32'h00010000;
                default: img[w] = (w < 9) ? 32'hFFFFFFFF :
                                  (((w - 9) % 4 == 0) ? 32'd1 : 32'd0);
            endcase
        end
    endtask

    initial begin
        int dn, nd, nw;
        int t[$];
        int ab, bb, cb;

        tab[0].mode = 2'd0;
        tab[0].exp  = {32'd18, 32'd12, 32'd6, 32'd18, 32'd12, 32'd6,
                       32'd18, 32'd12, 32'd6};
        tab[1].mode = 2'd1;
        tab[1].exp  = '0;
        tab[2].mode = 2'd2;
        tab[2].exp  = {9{32'hFFFFFFFF}};

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'({re, we}), 32'd0);
        check("rst_addr", addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        a_base = 32'd0;
        b_base = 32'd9;
        c_base = 32'd18;
        for (int v = 0; v < 3; v++) begin
            fill(tab[v].mode);
            load();
            run3(1'b0, dn, nd, nw);
            check("tab_done_at", 32'(dn), 32'd64);
            check("tab_ndone", 32'(nd), 32'd1);
            check("tab_writes", 32'(nw), 32'd9);
            for (int x = 0; x < 9; x++)
                check("tab_c", mem[18 + x], tab[v].exp[x*32 +: 32]);
        end

        // Random data and bases against the reference.
        for (int r = 0; r < 6; r++) begin
            ab = int'($urandom_range(0, 9));
            bb = int'($urandom_range(20, 29));
            cb = int'($urandom_range(40, 49));
            for (int w = 0; w < 64; w++) img[w] = $urandom;
            if (r == 0) for (int w = 0; w < 64; w++) img[w] |= 32'hF0000000;
            load();
            a_base = 32'(ab);
            b_base = 32'(bb);
            c_base = 32'(cb);
            run3(1'b0, dn, nd, nw);
            check("rnd_done_at", 32'(dn), 32'd64);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    check("rnd_c", mem[cb + i*3 + j], ref_c(ab, bb, i, j));
        end
        a_base = 32'd0;
        b_base = 32'd9;
        c_base = 32'd18;

        // Start while busy: pulses ignored.
        fill(2'd0);
        load();
        run3(1'b1, dn, nd, nw);
        check("busy_done_at", 32'(dn), 32'd64);
        check("busy_ndone", 32'(nd), 32'd1);
        check("busy_writes", 32'(nw), 32'd9);

        // Reset mid-run at access cycle 20.
        fill(2'd0);
        load();
        step();
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_en", 32'({re, we}), 32'd0);
        check("mrst_addr", addr, 32'd0);
        check("mrst_wd", wd, 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        check("mrst_c0", mem[18], 32'd6);
        check("mrst_c1", mem[19], 32'd12);
        for (int w = 20; w < 27; w++)
            check("mrst_keep", mem[w], 32'hDEAD0000 + 32'(w));
        repeat (5) step();
        check("mrst_idle", 32'(busy), 32'd0);
        run3(1'b0, dn, nd, nw);
        check("mrst_redo_at", 32'(dn), 32'd64);
        for (int x = 0; x < 9; x++)
            check("mrst_redo_c", mem[18 + x], tab[0].exp[x*32 +: 32]);

        // Back-to-back with start held high.
        fill(2'd0);
        load();
        step();
        start = 1'b1;
        for (int n = 1; n <= 300 && t.size() < 3; n++) begin
            step();
            if (done) t.push_back(n);
        end
        start = 1'b0;
        check("b2b_count", 32'(t.size()), 32'd3);
        if (t.size() == 3) begin
            check("b2b_first", 32'(t[0]), 32'd64);
            check("b2b_gap1", 32'(t[1] - t[0]), 32'd65);
            check("b2b_gap2", 32'(t[2] - t[1]), 32'd65);
        end
        repeat (3) step();
        check("b2b_idle", 32'(busy), 32'd0);
        for (int x = 0; x < 9; x++)
            check("b2b_c", mem[18 + x], tab[0].exp[x*32 +: 32]);

        // N=1 instance.
        for (int w = 0; w < 64; w++) img[w] = 32'd0;
        img[0] = 32'd7;
        img[1] = 32'd6;
        load();
        step();
        start1 = 1'b1;
        dn = -1;
        nw = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            start1 = 1'b0;
            if (re1 || we1) nw++;
            if (done1 && dn < 0) dn = n;
        end
        check("n1_access", 32'(nw), 32'd3);
        check("n1_done_at", 32'(dn), 32'd4);
        check("n1_c", mem1[2], 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule
